text_pixel_pipeline: RTL
========================

// Module: text_pixel_pipeline
// PURPOSE
//  Text-mode pixel renderer between the VGA timing generator and the HDMI encoder.
//  - Maps drawX/drawY to an 80x30 character cell and fetches the character byte from VRAM.
//  - Fetches the glyph row from the font ROM and produces 4-bit RGB per pixel.
//  - Uses the foreground/background colours from the control register (word 600).
//  - Delays hsync/vsync/vde so they stay aligned with the RGB output.
// PARAMETERS
//  COLS          80  characters per row
//  ROWS          30  character rows
//  GLYPH_W       8   glyph width, pixels
//  GLYPH_H       16  glyph height, pixels
//  VRAM_AW       10  VRAM word-address width (600 words used)
//  BLINK_FRAMES  30  frames per cursor blink half-period
// PORTS
//  pixel_clk   in   1   pixel clock, 25 MHz
//  arstn       in   1   reset, synchronous, active-low
//  drawX       in   10  current pixel column from timing generator
//  drawY       in   10  current pixel row from timing generator
//  hsync_i     in   1   horizontal sync, active-low
//  vsync_i     in   1   vertical sync, active-low
//  vde_i       in   1   video data enable (visible area)
//  ctrl_reg    in   32  control register: [24:13] fg {R,G,B}, [12:1] bg {R,G,B}
//  cursor_en   in   1   enable blinking cursor
//  cursor_pos  in   12  cursor character index, 0..2399
//  vram_addr   out  10  VRAM word address; synchronous read, 1-cycle latency
//  vram_rdata  in   32  VRAM word: 4 chars, byte n = char index 4*addr+n
//  font_addr   out  11  font ROM address {code[6:0], glyph_row[3:0]}; 1-cycle latency
//  font_data   in   8   glyph row, bit 7 = leftmost pixel
//  red/green/blue  out  4 each  pixel colour
//  hsync_o, vsync_o, vde_o   out  1 each  syncs/enable aligned with RGB
// BEHAVIOUR
//  Reset (arstn=0 at a pixel_clk edge): RGB=0, hsync_o=vsync_o=1, vde_o=0.
//   Pipeline regs, latched colours, frame counter, blink phase all cleared.
//   A mid-frame reset flushes the pipe; output resumes cleanly 3 cycles after release.
//  Character index: idx = (drawY>>4)*COLS + (drawX>>3); vram_addr = idx>>2.
//  Stage S0 (same cycle as drawX/drawY): drive vram_addr.
//   Register idx[1:0], drawY[3:0], drawX[2:0], syncs, vde, and cursor hit (idx==cursor_pos).
//  Stage S1: select byte idx[1:0] of vram_rdata.
//   bit7 = invert flag; bits[6:0] = code; font_addr = {code, rowY}.
//   Register invert, cursor hit, drawX[2:0], syncs, vde.
//  Stage S2: pix = font_data[7-drawX[2:0]].
//   inv = invert ^ (cursor_en & hit & blink_on).
//   colour = (pix ^ inv) ? fg : bg. Register RGB and syncs into the outputs.
//  Latency: exactly 3 pixel_clk from drawX/drawY/syncs in to RGB/syncs out.
//   hsync/vsync/vde delayed by the same 3 cycles.
//  When the delayed vde is 0, RGB is forced to 0.
//  Frame start = vsync_i falling edge (registered prev=1, current=0). At frame start:
//   - fg/bg are loaded from ctrl_reg. They are held for the rest of the frame (no tearing).
//   - A ctrl_reg change in the same cycle as the edge is taken.
//   - The frame counter increments; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
//  After reset the latched colours are 0 (black on black) until the first frame start.
//  cursor_pos >= 2400 never matches. Out-of-range drawX/drawY only occur with vde_i=0,
//   so the resulting addresses are don't-care.
// TESTING
//  1. Reset, hold ctrl=0x001F6000, run past a vsync fall. VRAM byte@idx0 = 0x41.
//     -> pixels (0..7,0) follow font 'A' row 0, fg=0x0FB, bg=0x000.
//  2. Drive syncs/vde pulse at cycle N -> each appears on outputs at cycle N+3, matching RGB.
//  3. VRAM word 0 = 0x80000000 (char 3 inverted): pixels x=24..31
//     -> fg/bg swapped relative to x=16..23.
//  4. Change ctrl_reg mid-frame -> output colours unchanged until the next vsync fall,
//     then new values applied.
//  5. cursor_en=1, cursor_pos=81 -> cell (1,1) inverted for 30 frames, normal for 30, repeating.
//  6. Assert arstn=0 mid-line for 2 cycles -> RGB=0, hsync_o=vsync_o=1, vde_o=0 next edge;
//     correct pixels 3 cycles after release.

Source files
------------

// File: rtl/text_pixel_pipeline_if.sv
// Memory-side bus of the text renderer: VRAM character fetch and font ROM
// glyph fetch. Both memories are synchronous-read with one cycle of latency.
interface text_pixel_pipeline_if #(
  parameter int VRAM_AW = 10
);
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_rdata;
  logic [10:0]        font_addr;
  logic [7:0]         font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_rdata,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_rdata,
    output font_data
  );
endinterface

// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel renderer: drawX/drawY -> character cell -> VRAM byte ->
// font row -> 4-bit RGB. Three register stages; syncs and vde ride along so
// they leave aligned with the colour. Colours and cursor blink phase change
// only at frame start (vsync falling edge) to avoid tearing.
module text_pixel_pipeline #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int VRAM_AW      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pixel_clk,
  input  logic        arstn,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        vde_i,
  input  logic [31:0] ctrl_reg,
  input  logic        cursor_en,
  input  logic [11:0] cursor_pos,
  text_pixel_pipeline_if.master mem,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o
);

  localparam int XSH = $clog2(GLYPH_W);
  localparam int YSH = $clog2(GLYPH_H);
  localparam int CW  = $clog2(BLINK_FRAMES);
  localparam logic [11:0]   COLS_L  = 12'(COLS);
  localparam logic [11:0]   CELLS_L = 12'(COLS * ROWS);
  localparam logic [CW-1:0] LAST_FR = CW'(BLINK_FRAMES - 1);

  // ---------------- stage S0: cell index and VRAM address ----------------
  logic [11:0] cell_x, cell_y, idx_s0;
  logic        hit_s0;

  assign cell_x = 12'(drawX >> XSH);
  assign cell_y = 12'(drawY >> YSH);
  assign idx_s0 = cell_y * COLS_L + cell_x;
  // Out-of-range drawX/drawY only happen with vde_i low, so wrap is harmless.
  assign mem.vram_addr = idx_s0[VRAM_AW+1:2];
  // A cursor position past the last cell must never light a cell.
  assign hit_s0 = (idx_s0 == cursor_pos) && (cursor_pos < CELLS_L);

  logic [1:0]     sel_p0_q;
  logic [YSH-1:0] row_p0_q;
  logic [XSH-1:0] col_p0_q;
  logic           hs_p0_q, vs_p0_q, vld_p0_q, hit_p0_q;

  // S0 -> S1 pipeline register
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      sel_p0_q <= '0;
      row_p0_q <= '0;
      col_p0_q <= '0;
      hs_p0_q  <= 1'b1;
      vs_p0_q  <= 1'b1;
      vld_p0_q <= 1'b0;
      hit_p0_q <= 1'b0;
    end else begin
      sel_p0_q <= idx_s0[1:0];
      row_p0_q <= drawY[YSH-1:0];
      col_p0_q <= drawX[XSH-1:0];
      hs_p0_q  <= hsync_i;
      vs_p0_q  <= vsync_i;
      vld_p0_q <= vde_i;
      hit_p0_q <= hit_s0;
    end
  end

  // ---------------- stage S1: character byte and font address ------------
  logic [7:0] byte_s1;

  assign byte_s1       = mem.vram_rdata[{sel_p0_q, 3'b000} +: 8];
  assign mem.font_addr = {byte_s1[6:0], row_p0_q};

  logic           inv_p1_q, hit_p1_q;
  logic [XSH-1:0] col_p1_q;
  logic           hs_p1_q, vs_p1_q, vld_p1_q;

  // S1 -> S2 pipeline register
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      inv_p1_q <= 1'b0;
      hit_p1_q <= 1'b0;
      col_p1_q <= '0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      vld_p1_q <= 1'b0;
    end else begin
      inv_p1_q <= byte_s1[7];
      hit_p1_q <= hit_p0_q;
      col_p1_q <= col_p0_q;
      hs_p1_q  <= hs_p0_q;
      vs_p1_q  <= vs_p0_q;
      vld_p1_q <= vld_p0_q;
    end
  end

  // ---------------- frame-rate state: colours and blink ------------------
  logic          vs_prev_q;
  logic [11:0]   fg_q, fg_d, bg_q, bg_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;
  logic          frame_start;

  assign frame_start = vs_prev_q & ~vsync_i;

  // Next-state of latched colours and blink counter, updated only at frame start
  always_comb begin
    fg_d        = fg_q;
    bg_d        = bg_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      fg_d = ctrl_reg[24:13];
      bg_d = ctrl_reg[12:1];
      if (frame_cnt_q == LAST_FR) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Frame-rate state register; colours read black on black until first frame
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vs_prev_q   <= 1'b0;
      fg_q        <= '0;
      bg_q        <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      vs_prev_q   <= vsync_i;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // ---------------- stage S2: pixel select and colour --------------------
  logic        pix_s2, inv_s2;
  logic [11:0] rgb_d;

  // Pick the glyph bit, apply invert/cursor, blank outside the visible area
  always_comb begin
    rgb_d  = 12'h000;
    pix_s2 = mem.font_data[XSH'(GLYPH_W - 1) - col_p1_q];
    inv_s2 = inv_p1_q ^ (cursor_en & hit_p1_q & blink_q);
    if (vld_p1_q) rgb_d = (pix_s2 ^ inv_s2) ? fg_q : bg_q;
  end

  // S2 -> output register
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      vde_o   <= 1'b0;
    end else begin
      red     <= rgb_d[11:8];
      green   <= rgb_d[7:4];
      blue    <= rgb_d[3:0];
      hsync_o <= hs_p1_q;
      vsync_o <= vs_p1_q;
      vde_o   <= vld_p1_q;
    end
  end

  // Control-register bits outside the colour fields carry other functions.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_reg[31:25], ctrl_reg[0]};

endmodule
